// File: rtl/fifo_rd_packer_if.sv
// Purpose: bundles the show-ahead FIFO read port, the flush request and the
//          packed valid/ready output of fifo_rd_packer into one port.
// Ports:   rdata/rempty/rinc  FIFO read side (rinc pops on the rclk edge)
//          flush              level request to emit a partial packed word
//          pdata/pcount/pvalid/pready  packed word output handshake
// Modports: master = packer side, slave = FIFO/downstream environment side.
interface fifo_rd_packer_if #(
   parameter int DSIZE = 8,
   parameter int RATIO = 4
);
   localparam int CW = $clog2(RATIO) + 1;

   logic [DSIZE-1:0]       rdata;
   logic                   rempty;
   logic                   rinc;
   logic                   flush;
   logic [DSIZE*RATIO-1:0] pdata;
   logic [CW-1:0]          pcount;
   logic                   pvalid;
   logic                   pready;

   modport master (
      input  rdata, rempty, flush, pready,
      output rinc, pdata, pcount, pvalid
   );

   modport slave (
      output rdata, rempty, flush, pready,
      input  rinc, pdata, pcount, pvalid
   );
endinterface

// File: rtl/fifo_rd_packer.sv
// Purpose: pops DSIZE-bit words from a show-ahead FIFO and packs RATIO of them into one wide word.
// Latency: pvalid rises on the same edge that pops the RATIO-th word (or on the flush edge).
// Backpressure: keeps popping until only the final lane is missing, then stalls with that word left in the FIFO.
//
// Ports:
//   rclk        read-domain clock, all state updates on the rising edge
//   rrst        synchronous active-high reset; also forces rinc low
//   pk.rdata    FIFO head word (valid while rempty=0)
//   pk.rempty   FIFO empty flag
//   pk.rinc     pop strobe
//   pk.flush    level request to emit the current partial word
//   pk.pdata    packed word, lane k = pdata[k*DSIZE +: DSIZE]
//   pk.pcount   number of valid lanes in pdata (1..RATIO)
//   pk.pvalid   pdata/pcount valid
//   pk.pready   downstream accepts on an edge with pvalid && pready
module fifo_rd_packer #(
   parameter int DSIZE     = 8,
   parameter int RATIO     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             rclk,
   input  logic             rrst,
   fifo_rd_packer_if.master pk
);
   localparam int            CW   = $clog2(RATIO) + 1;
   localparam int            WW   = DSIZE * RATIO;
   localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
   localparam logic [CW-1:0] FULL = CW'(RATIO);

   logic [WW-1:0] acc;
   logic [WW-1:0] acc_merged;
   logic [WW-1:0] pdata_q;
   logic [CW-1:0] cnt;
   logic [CW-1:0] pcount_q;
   logic [CW-1:0] lane_idx;
   logic          pvalid_q;
   logic          slot_free;
   logic          pop;
   logic          complete;
   logic          flush_go;

   // Output register is empty, or it is being drained on this edge.
   assign slot_free = !pvalid_q || pk.pready;

   // The last lane may only be popped when the finished word has somewhere
   // to go; earlier lanes keep filling even under backpressure.
   assign pop      = !rrst && !pk.rempty && !pk.flush && ((cnt != LAST) || slot_free);
   assign complete = pop && (cnt == LAST);
   assign flush_go = pk.flush && (cnt != '0) && slot_free;

   assign lane_idx = LSB_FIRST ? cnt : (LAST - cnt);

   // Accumulator with the FIFO head word written into the current lane.
   always_comb begin
      acc_merged = acc;
      for (int k = 0; k < RATIO; k++) begin
         if (lane_idx == CW'(k)) begin
            acc_merged[k*DSIZE +: DSIZE] = pk.rdata;
         end
      end
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         acc      <= '0;
         cnt      <= '0;
         pdata_q  <= '0;
         pcount_q <= '0;
         pvalid_q <= 1'b0;
      end else if (complete) begin
         // Loading while draining keeps pvalid high: zero-bubble handoff.
         pdata_q  <= acc_merged;
         pcount_q <= FULL;
         pvalid_q <= 1'b1;
         acc      <= '0;
         cnt      <= '0;
      end else if (flush_go) begin
         // Unfilled lanes are already zero because acc is cleared on every emit.
         pdata_q  <= acc;
         pcount_q <= cnt;
         pvalid_q <= 1'b1;
         acc      <= '0;
         cnt      <= '0;
      end else begin
         if (pop) begin
            acc <= acc_merged;
            cnt <= cnt + CW'(1);
         end
         if (pvalid_q && pk.pready) begin
            pvalid_q <= 1'b0;
         end
      end
   end

   assign pk.rinc   = pop;
   assign pk.pdata  = pdata_q;
   assign pk.pcount = pcount_q;
   assign pk.pvalid = pvalid_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: two instances (LSB-first and MSB-first) share one
// FIFO model, flush and pready; expected packed words are queued as stimulus
// is loaded and compared whenever an output transfer happens.
module tb_fifo_rd_packer;
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  c;
   } exp_t;

   logic       rclk;
   logic       rrst;
   logic       flush;
   logic       pready;
   logic       rempty_d;
   logic [7:0] rdata_d;

   fifo_rd_packer_if #(.DSIZE(8), .RATIO(4)) ifa ();
   fifo_rd_packer_if #(.DSIZE(8), .RATIO(4)) ifb ();

   assign ifa.rdata  = rdata_d;
   assign ifa.rempty = rempty_d;
   assign ifa.flush  = flush;
   assign ifa.pready = pready;
   assign ifb.rdata  = rdata_d;
   assign ifb.rempty = rempty_d;
   assign ifb.flush  = flush;
   assign ifb.pready = pready;

   fifo_rd_packer #(.DSIZE(8), .RATIO(4), .LSB_FIRST(1'b1)) dut_a (
      .rclk(rclk), .rrst(rrst), .pk(ifa)
   );
   fifo_rd_packer #(.DSIZE(8), .RATIO(4), .LSB_FIRST(1'b0)) dut_b (
      .rclk(rclk), .rrst(rrst), .pk(ifb)
   );

   initial begin
      rclk = 1'b0;
      forever #5 rclk = ~rclk;
   end

   logic [7:0]  fifo_q[$];
   exp_t        exp_q[$];
   bit          gap;
   bit          gap_en;
   bit          rdy_rand;
   int          n_cmp;
   int          n_err;
   int          n_pops;
   int          n_vld;
   logic        s_rinc;
   logic        s_pvalid;
   logic [31:0] s_pdata_a;
   logic [31:0] s_pdata_b;
   logic [2:0]  s_pcount;
   logic        p_hold;
   logic [31:0] p_pdata_a;
   logic [2:0]  p_pcount;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
      exp_t e;
      e.a = a;
      e.b = b;
      e.c = c;
      exp_q.push_back(e);
   endtask

   task automatic push_words(input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input logic [7:0] w3);
      fifo_q.push_back(w0);
      fifo_q.push_back(w1);
      fifo_q.push_back(w2);
      fifo_q.push_back(w3);
   endtask

   // One clock cycle: drive the FIFO head, sample and check at the falling
   // edge, then retire a popped word after the rising edge.
   task automatic tick();
      exp_t e;
      rempty_d = gap || (fifo_q.size() == 0);
      rdata_d  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
      @(negedge rclk);
      s_rinc    = ifa.rinc;
      s_pvalid  = ifa.pvalid;
      s_pdata_a = ifa.pdata;
      s_pdata_b = ifb.pdata;
      s_pcount  = ifa.pcount;
      chk("rinc_lane_indep", ifb.rinc, s_rinc);
      chk("pvalid_lane_indep", ifb.pvalid, s_pvalid);
      if (rempty_d) chk("rinc_when_empty", s_rinc, 1'b0);
      if (flush)    chk("rinc_during_flush", s_rinc, 1'b0);
      if (rrst)     chk("rinc_during_reset", s_rinc, 1'b0);
      if (p_hold) begin
         chk("hold_pdata", s_pdata_a, p_pdata_a);
         chk("hold_pcount", s_pcount, p_pcount);
      end
      if (!rrst && s_pvalid && pready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", s_pvalid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk("pdata_lsb_first", s_pdata_a, e.a);
            chk("pdata_msb_first", s_pdata_b, e.b);
            chk("pcount_lsb_first", s_pcount, e.c);
            chk("pcount_msb_first", ifb.pcount, e.c);
         end
      end
      p_hold    = s_pvalid && !pready && !rrst;
      p_pdata_a = s_pdata_a;
      p_pcount  = s_pcount;
      if (s_rinc)   n_pops++;
      if (s_pvalid) n_vld++;
      @(posedge rclk);
      #1;
      if (s_rinc) void'(fifo_q.pop_front());
      gap = gap_en && ($urandom_range(0, 2) == 0);
      if (rdy_rand) pready = ($urandom_range(0, 1) == 1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      n_cmp = 0; n_err = 0; n_pops = 0; n_vld = 0;
      gap = 0; gap_en = 0; rdy_rand = 0; p_hold = 0;
      p_pdata_a = '0; p_pcount = '0;
      rrst = 1'b1; flush = 1'b0; pready = 1'b1;
      rempty_d = 1'b1; rdata_d = 8'h00;

      // Reset with a non-empty FIFO: no pops, outputs cleared.
      push_words(8'h11, 8'h22, 8'h33, 8'h44);
      tick();
      chk("rst_rinc_c1", s_rinc, 1'b0);
      tick();
      chk("rst_rinc_c2", s_rinc, 1'b0);
      chk("rst_pvalid", s_pvalid, 1'b0);
      chk("rst_pdata_a", s_pdata_a, 32'h0);
      chk("rst_pdata_b", s_pdata_b, 32'h0);
      chk("rst_pcount", s_pcount, 3'd0);
      chk("rst_no_pops", n_pops, 0);
      rrst = 1'b0;

      // Basic pack, pready=1.
      n_pops = 0; n_vld = 0;
      push_exp(32'h44332211, 32'h11223344, 3'd4);
      run(4);
      chk("basic_consecutive_pops", n_pops, 4);
      run(2);
      chk("basic_pvalid_cycles", n_vld, 1);
      chk("basic_all_out", exp_q.size(), 0);

      // Backpressure: fills the next word up to its last lane, then stalls.
      pready = 1'b0;
      n_pops = 0;
      for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
      push_exp(32'h04030201, 32'h01020304, 3'd4);
      push_exp(32'h08070605, 32'h05060708, 3'd4);
      run(10);
      chk("bp_pops", n_pops, 7);
      chk("bp_stall_rinc", s_rinc, 1'b0);
      chk("bp_fifo_left", fifo_q.size(), 1);
      chk("bp_held_pdata", s_pdata_a, 32'h04030201);
      chk("bp_held_pvalid", s_pvalid, 1'b1);
      pready = 1'b1;
      tick();
      tick();
      chk("bp_zero_bubble", s_pvalid, 1'b1);
      chk("bp_second_word", s_pdata_a, 32'h08070605);
      tick();
      chk("bp_drained", s_pvalid, 1'b0);
      chk("bp_all_out", exp_q.size(), 0);

      // Flush a partial word, then flush on an empty accumulator.
      n_pops = 0;
      fifo_q.push_back(8'hAA);
      fifo_q.push_back(8'hBB);
      run(3);
      chk("flush_prepops", n_pops, 2);
      fifo_q.push_back(8'hCC);
      flush = 1'b1;
      push_exp(32'h0000BBAA, 32'hAABB0000, 3'd2);
      tick();
      tick();
      chk("flush_pvalid", s_pvalid, 1'b1);
      chk("flush_pcount", s_pcount, 3'd2);
      tick();
      tick();
      chk("flush_empty_noop", s_pvalid, 1'b0);
      chk("flush_no_pops", n_pops, 2);
      chk("flush_fifo_kept", fifo_q.size(), 1);
      flush = 1'b0;

      // Random rempty gaps and pready toggling, continuing from lane CC.
      fifo_q.push_back(8'hDD);
      fifo_q.push_back(8'hEE);
      fifo_q.push_back(8'hFF);
      push_words(8'h11, 8'h22, 8'h33, 8'h44);
      push_exp(32'hFFEEDDCC, 32'hCCDDEEFF, 3'd4);
      push_exp(32'h44332211, 32'h11223344, 3'd4);
      gap_en = 1; rdy_rand = 1;
      run(80);
      gap_en = 0; rdy_rand = 0; pready = 1'b1;
      run(3);
      chk("rand_all_out", exp_q.size(), 0);
      chk("rand_fifo_empty", fifo_q.size(), 0);

      // Reset mid-packet discards the two popped lanes.
      fifo_q.push_back(8'hA1);
      fifo_q.push_back(8'hA2);
      run(2);
      rrst = 1'b1;
      tick();
      rrst = 1'b0;
      fifo_q.push_back(8'h5A);
      run(2);
      flush = 1'b1;
      push_exp(32'h0000005A, 32'h5A000000, 3'd1);
      run(2);
      flush = 1'b0;
      push_words(8'h55, 8'h66, 8'h77, 8'h88);
      push_exp(32'h88776655, 32'h55667788, 3'd4);
      run(6);
      chk("midrst_all_out", exp_q.size(), 0);
      chk("midrst_last_pdata", s_pdata_a, 32'h88776655);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
